// File: rtl/puf_pkg.sv
`timescale 1ns/100ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : puf_pkg                                                         |
// | Brief    : Shared types for the RO PUF response reader.                    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package puf_pkg;

    localparam int CHALLENGE_W = 12;
    localparam int CFG_W       = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        COUNT  = 3'd2,
        STOP   = 3'd3,
        DONE   = 3'd4
    } rd_state_t;

    typedef struct packed {
        logic [CFG_W-1:0] sel_b;
        logic [CFG_W-1:0] bx_b;
        logic [CFG_W-1:0] sel_a;
        logic [CFG_W-1:0] bx_a;
    } challenge_t;

endpackage
`default_nettype wire

// File: rtl/ro_edge_counter.sv
`timescale 1ns/100ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ro_edge_counter                                                 |
// | Brief    : Synchronizes an oscillator output, detects rising edges and     |
// |            counts them with saturation.                                    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ro_edge_counter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ro,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;
    logic             r_prev;
    logic [CNT_W-1:0] r_count;
    logic             w_rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_ro};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_count <= '0;
        end else if (i_en && w_rise && (r_count != C_CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ro_response_reader.sv
`timescale 1ns/100ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ro_response_reader                                              |
// | Brief    : Runs one challenge on a ring-oscillator pair, counts edges over |
// |            a fixed gate window and produces one response bit.             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ro_response_reader
    import puf_pkg::*;
#(
    parameter int WINDOW_CYC  = 4096,
    parameter int SETTLE_CYC  = 16,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   START,
    input  logic [CHALLENGE_W-1:0] CHALLENGE,
    output logic                   BUSY,
    output logic                   RO_EN,
    output logic [CFG_W-1:0]       SEL_A,
    output logic [CFG_W-1:0]       BX_A,
    output logic [CFG_W-1:0]       SEL_B,
    output logic [CFG_W-1:0]       BX_B,
    input  logic                   RO_A,
    input  logic                   RO_B,
    output logic                   RESP,
    output logic                   TIE,
    output logic                   RESP_VALID,
    input  logic                   RESP_READY,
    output logic [CNT_W-1:0]       COUNT_A,
    output logic [CNT_W-1:0]       COUNT_B
);

    localparam int C_TMR_MAX = (WINDOW_CYC > SETTLE_CYC) ? WINDOW_CYC : SETTLE_CYC;
    localparam int C_TMR_W   = $clog2(C_TMR_MAX + 1);
    localparam logic [C_TMR_W-1:0] C_SETTLE_LAST = C_TMR_W'(SETTLE_CYC - 1);
    localparam logic [C_TMR_W-1:0] C_WINDOW_LAST = C_TMR_W'(WINDOW_CYC - 1);

    rd_state_t        r_state;
    rd_state_t        w_state_nxt;
    logic [C_TMR_W-1:0] r_tmr;
    challenge_t       r_cfg;
    logic             r_ro_en;
    logic             r_resp;
    logic             r_tie;
    logic [CNT_W-1:0] r_count_a;
    logic [CNT_W-1:0] r_count_b;
    logic [CNT_W-1:0] w_cnt_a;
    logic [CNT_W-1:0] w_cnt_b;
    logic             w_cnt_clr;
    logic             w_cnt_en;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_clr = 1'b1;
                if (START) w_state_nxt = SETTLE;
            end
            SETTLE: begin
                w_cnt_clr = 1'b1;
                if (r_tmr == C_SETTLE_LAST) w_state_nxt = COUNT;
            end
            COUNT: begin
                w_cnt_en = 1'b1;
                if (r_tmr == C_WINDOW_LAST) w_state_nxt = STOP;
            end
            STOP:    w_state_nxt = DONE;
            DONE:    if (RESP_READY) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Timer restarts on every state change so SETTLE and COUNT each start at zero.
    always_ff @(posedge CLK) begin
        if (!RST_N || (w_state_nxt != r_state)) begin
            r_tmr <= '0;
        end else if ((r_state == SETTLE) || (r_state == COUNT)) begin
            r_tmr <= r_tmr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_cfg   <= '0;
            r_ro_en <= 1'b0;
        end else begin
            if ((r_state == IDLE) && START) begin
                r_cfg <= challenge_t'(CHALLENGE);
            end
            r_ro_en <= (w_state_nxt == SETTLE) || (w_state_nxt == COUNT);
        end
    end

    ro_edge_counter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cnt_a (
        .clk     (CLK),
        .rst_n   (RST_N),
        .i_ro    (RO_A),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_cnt_a)
    );

    ro_edge_counter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cnt_b (
        .clk     (CLK),
        .rst_n   (RST_N),
        .i_ro    (RO_B),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_cnt_b)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_count_a <= '0;
            r_count_b <= '0;
            r_resp    <= 1'b0;
            r_tie     <= 1'b0;
        end else if (r_state == STOP) begin
            r_count_a <= w_cnt_a;
            r_count_b <= w_cnt_b;
            r_resp    <= (w_cnt_a > w_cnt_b);
            r_tie     <= (w_cnt_a == w_cnt_b);
        end
    end

    assign BUSY       = (r_state != IDLE);
    assign RESP_VALID = (r_state == DONE);
    assign RO_EN      = r_ro_en;
    assign SEL_A      = r_cfg.sel_a;
    assign BX_A       = r_cfg.bx_a;
    assign SEL_B      = r_cfg.sel_b;
    assign BX_B       = r_cfg.bx_b;
    assign RESP       = r_resp;
    assign TIE        = r_tie;
    assign COUNT_A    = r_count_a;
    assign COUNT_B    = r_count_b;

endmodule
`default_nettype wire

// File: tb/tb_ro_response_reader.sv
`timescale 1ns/100ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ro_response_reader                                           |
// | Brief    : Self-checking bench; ideal edge-count model over the gate window.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_ro_response_reader;

    localparam int WINDOW_CYC = 100;
    localparam int SETTLE_CYC = 4;
    localparam int CLK_NS     = 10;
    localparam int WINDOW_NS  = WINDOW_CYC * CLK_NS;
    localparam int LATENCY    = SETTLE_CYC + WINDOW_CYC + 2;
    localparam int SAT4       = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] challenge = '0;
    logic        resp_ready = 1'b0;
    logic        ro_a_osc = 1'b0;
    logic        ro_b_osc = 1'b0;
    logic        tie_mode = 1'b0;
    logic        ro_a;
    logic        ro_b;
    int          half_a = 20;
    int          half_b = 30;

    logic       busy, ro_en, resp, tie, resp_valid;
    logic [2:0] sel_a, bx_a, sel_b, bx_b;
    logic [7:0] count_a, count_b;
    logic       busy4, ro_en4, resp4, tie4, resp_valid4;
    logic [2:0] sel_a4, bx_a4, sel_b4, bx_b4;
    logic [3:0] count_a4, count_b4;

    int n_chk = 0;
    int n_err = 0;

    assign ro_a = ro_a_osc;
    assign ro_b = tie_mode ? ro_a_osc : ro_b_osc;

    always #(CLK_NS/2) clk = ~clk;

    // Oscillator edges sit on half-ns points so they never coincide with a clock edge.
    initial begin
        #0.5;
        forever begin
            #(half_a) ro_a_osc = ~ro_a_osc;
        end
    end
    initial begin
        #0.5;
        forever begin
            #(half_b) ro_b_osc = ~ro_b_osc;
        end
    end

    ro_response_reader #(
        .WINDOW_CYC (WINDOW_CYC), .SETTLE_CYC (SETTLE_CYC), .CNT_W (8), .SYNC_STAGES (2)
    ) dut (
        .CLK (clk), .RST_N (rst_n), .START (start), .CHALLENGE (challenge),
        .BUSY (busy), .RO_EN (ro_en), .SEL_A (sel_a), .BX_A (bx_a),
        .SEL_B (sel_b), .BX_B (bx_b), .RO_A (ro_a), .RO_B (ro_b),
        .RESP (resp), .TIE (tie), .RESP_VALID (resp_valid), .RESP_READY (resp_ready),
        .COUNT_A (count_a), .COUNT_B (count_b)
    );

    ro_response_reader #(
        .WINDOW_CYC (WINDOW_CYC), .SETTLE_CYC (SETTLE_CYC), .CNT_W (4), .SYNC_STAGES (2)
    ) dut4 (
        .CLK (clk), .RST_N (rst_n), .START (start), .CHALLENGE (challenge),
        .BUSY (busy4), .RO_EN (ro_en4), .SEL_A (sel_a4), .BX_A (bx_a4),
        .SEL_B (sel_b4), .BX_B (bx_b4), .RO_A (ro_a), .RO_B (ro_b),
        .RESP (resp4), .TIE (tie4), .RESP_VALID (resp_valid4), .RESP_READY (resp_ready),
        .COUNT_A (count_a4), .COUNT_B (count_b4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // A window of WINDOW_NS holds floor or ceil(WINDOW_NS/period) rising edges.
    function automatic int lo_cnt(input int half, input int sat);
        int v;
        v = WINDOW_NS / (2 * half);
        return (v > sat) ? sat : v;
    endfunction

    function automatic int hi_cnt(input int half, input int sat);
        int v;
        v = WINDOW_NS / (2 * half) + (((WINDOW_NS % (2 * half)) != 0) ? 1 : 0);
        return (v > sat) ? sat : v;
    endfunction

    function automatic int nearest(input int obs, input int lo, input int hi);
        if (obs < lo) return lo;
        if (obs > hi) return hi;
        return obs;
    endfunction

    // 0: undetermined, 1: A larger, 2: B larger, 3: equal
    function automatic int relation(input int la, input int ha, input int lb, input int hb,
                                    input bit same);
        if (same || (la == ha && lb == hb && la == lb)) return 3;
        if (la > hb) return 1;
        if (lb > ha) return 2;
        return 0;
    endfunction

    task automatic check_result(input string pfx, input int rel, input logic r, input logic t);
        if (rel != 0) begin
            check({pfx, "resp"}, 32'(r), 32'(rel == 1));
            check({pfx, "tie"},  32'(t), 32'(rel == 3));
        end
    endtask

    task automatic run_measure(input int ha, input int hb, input bit same,
                               input logic [11:0] chal, input int hold);
        int cyc;
        bit seen;
        logic [11:0] exp_cfg;
        logic [31:0] snap;
        int la, ua, lb, ub, la4, ua4, lb4, ub4;
        half_a   = ha;
        half_b   = hb;
        tie_mode = same;
        exp_cfg  = {chal[5:3], chal[2:0], chal[11:9], chal[8:6]};
        repeat (3) @(negedge clk);
        start     = 1'b1;
        challenge = chal;
        @(negedge clk);
        start     = 1'b0;
        challenge = ~chal;
        cyc       = 1;
        check("cfg_capture", {sel_a, bx_a, sel_b, bx_b}, exp_cfg);
        check("busy_start", busy, 1);
        check("ro_en_first", ro_en, 1);
        seen = 0;
        while (!seen && cyc < 4 * LATENCY) begin
            if (cyc == 30) start = 1'b1;
            if (cyc == 31) start = 1'b0;
            if (cyc == 50) resp_ready = 1'b1;
            if (cyc == 53) resp_ready = 1'b0;
            if (cyc == LATENCY - 2) check("ro_en_last", ro_en, 1);
            if (cyc == LATENCY - 1) check("ro_en_stop", ro_en, 0);
            if (resp_valid) seen = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("latency", cyc, LATENCY);
        if (!seen) return;
        check("valid4", resp_valid4, 1);
        check("cfg_held", {sel_a, bx_a, sel_b, bx_b}, exp_cfg);

        la = lo_cnt(ha, 255);  ua = hi_cnt(ha, 255);
        lb = lo_cnt(same ? ha : hb, 255); ub = hi_cnt(same ? ha : hb, 255);
        la4 = lo_cnt(ha, SAT4); ua4 = hi_cnt(ha, SAT4);
        lb4 = lo_cnt(same ? ha : hb, SAT4); ub4 = hi_cnt(same ? ha : hb, SAT4);
        check("count_a", count_a, nearest(count_a, la, ua));
        check("count_b", count_b, nearest(count_b, lb, ub));
        check("count_a4", count_a4, nearest(count_a4, la4, ua4));
        check("count_b4", count_b4, nearest(count_b4, lb4, ub4));
        check_result("w8_", relation(la, ua, lb, ub, same), resp, tie);
        check_result("w4_", relation(la4, ua4, lb4, ub4, same), resp4, tie4);

        snap = {resp, tie, count_a, count_b, sel_a, bx_a, sel_b, bx_b};
        repeat (hold) @(negedge clk);
        check("hold_valid", resp_valid, 1);
        check("hold_stable", {resp, tie, count_a, count_b, sel_a, bx_a, sel_b, bx_b}, snap);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("accept_busy", busy, 0);
        check("accept_valid", resp_valid, 0);
    endtask

    task automatic run_reset_midcount();
        half_a   = 20;
        half_b   = 30;
        tie_mode = 1'b0;
        @(negedge clk);
        start     = 1'b1;
        challenge = 12'h5A3;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_ro_en", ro_en, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_counts", {count_a, count_b}, 0);
        check("rst_cfg", {sel_a, bx_a, sel_b, bx_b}, 0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ha, hb;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_ro_en", ro_en, 0);
        check("reset_out", {resp, tie, resp_valid}, 0);
        check("reset_counts", {count_a, count_b}, 0);
        check("reset_cfg", {sel_a, bx_a, sel_b, bx_b}, 0);
        rst_n = 1'b1;

        run_measure(20, 30, 1'b0, 12'hA5C, 20);
        run_measure(30, 20, 1'b0, 12'($urandom), 5);
        run_measure(25, 25, 1'b1, 12'($urandom), 0);
        run_measure(10, 30, 1'b0, 12'($urandom), 3);
        run_reset_midcount();
        run_measure(20, 30, 1'b0, 12'($urandom), 0);

        for (int i = 0; i < 5; i++) begin
            do begin
                ha = int'($urandom_range(12, 100));
                hb = int'($urandom_range(12, 100));
            end while (WINDOW_NS * ((ha > hb) ? (ha - hb) : (hb - ha)) * 2 <
                       3 * (2 * ha) * (2 * hb));
            run_measure(ha, hb, 1'b0, 12'($urandom), int'($urandom_range(0, 20)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
